// File: rtl/shift_seq_pkg.sv
// Shared types and width helpers for the shift sequencer controller.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width needed to hold a shift count in the range 0..data_wid.
    function automatic int len_width(input int data_wid);
        return $clog2(data_wid + 1);
    endfunction

endpackage

// File: rtl/bidir_shift_core.sv
// Bidirectional single-bit shift register; clear takes priority over shift.
module bidir_shift_core #(
    parameter int DATA_WID = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                dir,
    input  logic                din,
    output logic [DATA_WID-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (dir) begin
                q <= {q[DATA_WID-2:0], din};
            end else begin
                q <= {din, q[DATA_WID-1:1]};
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command-driven shift sequencer: accepts a shift command, serialises bits
// from a data word into a bidirectional shift register, and hands back the result.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_SHIFT | one shift per edge until len steps are done or abort
//   ST_DONE  | result presented, held until res_ready
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int DATA_WID = 8,
    parameter int LEN_W    = len_width(DATA_WID)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_WID-1:0] cmd_data,
    input  logic                cmd_clr,
    input  logic                abort,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_WID-1:0] res_data,
    output logic [DATA_WID-1:0] shreg,
    output logic                busy
);

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    step_q, len_q, eff_len;
    logic                dir_q;
    logic [DATA_WID-1:0] data_q, data_rev, sel_word;
    logic                accept, core_en, core_clr, core_din;

    assign accept  = cmd_valid && (state == ST_IDLE);
    assign eff_len = (cmd_len > LEN_W'(DATA_WID)) ? LEN_W'(DATA_WID) : cmd_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            step_q <= '0;
            len_q  <= '0;
            dir_q  <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                step_q <= '0;
                len_q  <= eff_len;
                dir_q  <= cmd_dir;
                data_q <= cmd_data;
            end else if (core_en) begin
                step_q <= step_q + LEN_W'(1);
            end
        end
    end

    // MSB-first serialisation for dir=1 is done by reversing the word, so both
    // directions pick bit 'step' of a word and a full shift reproduces data.
    always_comb begin
        data_rev = '0;
        for (int i = 0; i < DATA_WID; i++) begin
            data_rev[i] = data_q[DATA_WID-1-i];
        end
    end

    assign sel_word = (dir_q ? data_rev : data_q) >> step_q;
    assign core_din = sel_word[0];

    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        core_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    core_clr  = cmd_clr;
                    state_nxt = (eff_len == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    core_en = 1'b1;
                    if (step_q == len_q - LEN_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    bidir_shift_core #(
        .DATA_WID (DATA_WID)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (core_en),
        .clr   (core_clr),
        .dir   (dir_q),
        .din   (core_din),
        .q     (shreg)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_DONE);
    assign res_data  = res_valid ? shreg : '0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl with DATA_WID=8.
module tb_shift_seq_ctrl;

    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_dir, cmd_clr, abort;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic          res_valid, res_ready, busy;
    logic [DW-1:0] res_data, shreg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(
        .DATA_WID (DW),
        .LEN_W    (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .cmd_clr   (cmd_clr),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .shreg     (shreg),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic clr, input logic dir, input logic [LW-1:0] len,
                         input logic [DW-1:0] data);
        cmd_valid = 1'b1;
        cmd_clr   = clr;
        cmd_dir   = dir;
        cmd_len   = len;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
    endtask

    task automatic pop(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_pop_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_pop_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0;
        cmd_data = '0; cmd_clr = 1'b0; abort = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data",  32'(res_data), 32'h00);
        chk("rst_shreg", 32'(shreg), 32'h00);
        #10 rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // full-length load, MSB-first
        issue(1'b1, 1'b1, 4'd8, 8'hA5);
        chk("a_busy",  32'(busy), 32'd1);
        chk("a_ready", 32'(cmd_ready), 32'd0);
        chk("a_clr",   32'(shreg), 32'h00);
        tick();
        chk("a_s1", 32'(shreg), 32'h01);
        tick();
        chk("a_s2", 32'(shreg), 32'h02);
        tick();
        chk("a_s3", 32'(shreg), 32'h05);
        repeat (4) tick();
        chk("a_s7",       32'(shreg), 32'h52);
        chk("a_s7_valid", 32'(res_valid), 32'd0);
        tick();
        chk("a_valid", 32'(res_valid), 32'd1);
        chk("a_data",  32'(res_data), 32'hA5);
        pop("a");

        // partial shift without clear
        issue(1'b0, 1'b1, 4'd4, 8'h0F);
        repeat (3) tick();
        chk("b_s3_valid", 32'(res_valid), 32'd0);
        tick();
        chk("b_valid", 32'(res_valid), 32'd1);
        chk("b_data",  32'(res_data), 32'h50);
        pop("b");

        // reload 0xA5 then shift toward LSB
        issue(1'b1, 1'b1, 4'd8, 8'hA5);
        repeat (8) tick();
        chk("c_load", 32'(res_data), 32'hA5);
        pop("c");
        issue(1'b0, 1'b0, 4'd3, 8'h07);
        tick();
        chk("c_s1", 32'(shreg), 32'hD2);
        tick();
        chk("c_s2", 32'(shreg), 32'hE9);
        tick();
        chk("c_s3",    32'(shreg), 32'hF4);
        chk("c_valid", 32'(res_valid), 32'd1);
        chk("c_data",  32'(res_data), 32'hF4);
        pop("c2");

        // zero length goes straight to DONE with prior contents
        issue(1'b0, 1'b1, 4'd0, 8'hFF);
        chk("z_valid", 32'(res_valid), 32'd1);
        chk("z_data",  32'(res_data), 32'hF4);
        pop("z");

        // over-length clamps to 8 shifts; then hold DONE with res_ready low
        issue(1'b1, 1'b1, 4'd12, 8'h3C);
        repeat (7) tick();
        chk("l_s7_valid", 32'(res_valid), 32'd0);
        tick();
        chk("l_valid", 32'(res_valid), 32'd1);
        chk("l_data",  32'(res_data), 32'h3C);
        cmd_valid = 1'b1; cmd_clr = 1'b1; cmd_len = 4'd8; cmd_data = 8'h00;
        abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("h_valid", 32'(res_valid), 32'd1);
            chk("h_data",  32'(res_data), 32'h3C);
            chk("h_ready", 32'(cmd_ready), 32'd0);
            chk("h_shreg", 32'(shreg), 32'h3C);
        end
        cmd_valid = 1'b0; cmd_clr = 1'b0; abort = 1'b0;
        pop("h");
        chk("h_after_shreg", 32'(shreg), 32'h3C);

        // abort after two shifts
        issue(1'b1, 1'b1, 4'd8, 8'hFF);
        repeat (2) tick();
        chk("ab_s2", 32'(shreg), 32'h03);
        abort = 1'b1;
        tick();
        chk("ab_busy",  32'(busy), 32'd0);
        chk("ab_valid", 32'(res_valid), 32'd0);
        chk("ab_shreg", 32'(shreg), 32'h03);
        tick();
        chk("ab_idle_shreg", 32'(shreg), 32'h03);
        chk("ab_idle_ready", 32'(cmd_ready), 32'd1);
        abort = 1'b0;

        // asynchronous reset in the middle of a shift
        issue(1'b1, 1'b1, 4'd8, 8'hA5);
        repeat (3) tick();
        chk("r_pre", 32'(shreg), 32'h05);
        #2 rst_n = 1'b0;
        #1;
        chk("r_shreg", 32'(shreg), 32'h00);
        chk("r_busy",  32'(busy), 32'd0);
        chk("r_valid", 32'(res_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("r_ready", 32'(cmd_ready), 32'd1);
        issue(1'b0, 1'b0, 4'd8, 8'h96);
        repeat (7) tick();
        chk("r2_s7_valid", 32'(res_valid), 32'd0);
        tick();
        chk("r2_valid", 32'(res_valid), 32'd1);
        chk("r2_data",  32'(res_data), 32'h96);
        pop("r2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WID, default 8, shift register width (>=2).
REQ-002 SHALL have parameter LEN_W, default $clog2(DATA_WID+1), width of shift-count field.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-007 SHALL have port cmd_dir  input  1  1 = shift toward MSB (serial bit enters LSB); 0 = shift toward LSB (serial bit enters MSB).
REQ-008 SHALL have port cmd_len  input  LEN_W  number of shifts requested.
REQ-009 SHALL have port cmd_data  input  DATA_WID  word supplying the serial bits.
REQ-010 SHALL have port cmd_clr  input  1  clear register on command accept.
REQ-011 SHALL have port abort  input  1  synchronous cancel of the running command.
REQ-012 SHALL have port res_valid  output  1  result available.
REQ-013 SHALL have port res_ready  input  1  result consumer ready.
REQ-014 SHALL have port res_data  output  DATA_WID  register contents at end of command.
REQ-015 SHALL have port shreg  output  DATA_WID  live shift register contents.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted on an edge with cmd_valid && cmd_ready.
REQ-019 On accept: latch dir, data, effective length; step counter = 0; shreg cleared to 0 if cmd_clr, else retained; next state SHIFT, or DONE if effective length is 0.
REQ-020 Effective length SHALL be min(cmd_len, DATA_WID).
REQ-021 In SHIFT, exactly one shift SHALL occur per edge, step k = 0..len-1.
REQ-022 Serial bit at step k SHALL be data[DATA_WID-1-k] when dir=1, data[k] when dir=0, so a full-length shift from any state reproduces data exactly.
REQ-023 dir=1 shift: shreg <= {shreg[DATA_WID-2:0], bit}; dir=0: shreg <= {bit, shreg[DATA_WID-1:1]}.
REQ-024 The edge performing step len-1 SHALL move the FSM to DONE; len shifts complete len edges after the accept edge.
REQ-025 In DONE, res_valid SHALL be 1 and res_data SHALL equal shreg; both SHALL hold stable until res_valid && res_ready; that edge returns to IDLE.
REQ-026 abort sampled high in SHIFT SHALL return to IDLE on that edge with no shift, no result; shreg keeps partial contents.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 shreg SHALL not change in IDLE or DONE.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, shreg 0, counter 0, latched command 0, at any time including mid-SHIFT.
REQ-030 During/after reset: cmd_ready=1 (once rst_n high), res_valid=0, res_data=0, busy=0.

Structure
REQ-031 Package shift_seq_pkg SHALL hold the state enum typedef and the LEN_W derivation constant/function.
REQ-032 A sub-module bidir_shift_core (DATA_WID, clk, rst_n, en, clr, dir, din, q) SHALL hold the register; the controller drives en/clr/dir/din.

Verification (DATA_WID=8)
REQ-033 clr=1, dir=1, len=8, data=0xA5 -> 8 shifts, res_valid after 8th shift, res_data=0xA5.
REQ-034 shreg=0xA5, clr=0, dir=1, len=4, data=0x0F -> res_data=0x50; then dir=0, len=3, data=0x07 from 0xA5 -> shreg 0xD2, 0xE9, 0xF4, res_data=0xF4.
REQ-035 len=0 -> DONE one edge after accept, res_data=prior shreg; len=12 -> exactly 8 shifts.
REQ-036 res_ready low 5 cycles in DONE -> res_valid, res_data stable, cmd_ready=0, new cmd_valid not accepted.
REQ-037 clr=1, dir=1, len=8, data=0xFF, abort after 2 shifts -> IDLE, no res_valid, shreg=0x03.
REQ-038 rst_n low during SHIFT -> shreg=0, busy=0, res_valid=0 immediately; next command executes normally.
